// File: rtl/lock_seq_ctrl.sv
// lock_seq_ctrl
//   Sequencing controller for the 4-bit combination lock. Turns the enter/init
//   key pulses and the comparator result into unlock, fail, lockout and
//   auto-relock behaviour, and keeps the remaining-attempt count.
//
//   Optional feature macro: LOCK_SEQ_PWD_CHANGE_EN
//     When defined, init_trig while OPEN writes a new password (pwd_we/pwd_wdata
//     from sw) and restarts the open period instead of relocking.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | locked, waiting for enter_trig
//   CHECK | waiting CMP_LAT cycles for the comparator, then sampling it
//   OPEN  | unlocked for OPEN_CYCLES or until enter_trig relocks
//   FAIL  | wrong entry indication for FAIL_CYCLES
//   LOCKOUT | no attempts left, alarm for LOCK_CYCLES
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   enter_trig in   one-cycle enter pulse
//   init_trig  in   one-cycle admin/init pulse
//   com_result in   comparator result (1 = match), valid CMP_LAT cycles after enter
//   sw         in   switch value, new password source (optional feature)
//   unlock     out  lock open (OPEN)
//   alarm      out  lockout active (LOCKOUT)
//   state_code out  0 IDLE, 1 CHECK, 2 OPEN, 3 FAIL, 4 LOCKOUT
//   tries_left out  remaining attempts
//   pwd_we     out  one-cycle password write strobe
//   pwd_wdata  out  new password value
module lock_seq_ctrl #(
    parameter int unsigned CMP_LAT     = 1,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned OPEN_CYCLES = 50000000,
    parameter int unsigned FAIL_CYCLES = 25000000,
    parameter int unsigned LOCK_CYCLES = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter_trig,
    input  logic       init_trig,
    input  logic       com_result,
    input  logic [3:0] sw,
    output logic       unlock,
    output logic       alarm,
    output logic [2:0] state_code,
    output logic [1:0] tries_left,
    output logic       pwd_we,
    output logic [3:0] pwd_wdata
);

    localparam int unsigned M1   = (CMP_LAT > OPEN_CYCLES) ? CMP_LAT : OPEN_CYCLES;
    localparam int unsigned M2   = (M1 > FAIL_CYCLES) ? M1 : FAIL_CYCLES;
    localparam int unsigned TMAX = (M2 > LOCK_CYCLES) ? M2 : LOCK_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] T_CMP  = TW'(CMP_LAT);
    localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES);
    localparam logic [TW-1:0] T_FAIL = TW'(FAIL_CYCLES);
    localparam logic [TW-1:0] T_LOCK = TW'(LOCK_CYCLES);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [1:0]    TRIES_MAX = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_FAIL    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          pwd_load;
    logic          admin_clr;

`ifdef LOCK_SEQ_PWD_CHANGE_EN
    assign pwd_load = init_trig && (state == S_OPEN);
`else
    assign pwd_load = 1'b0;
`endif
    assign admin_clr = init_trig && !pwd_load;

    // Timed states load their length on entry and leave on the cycle the timer
    // would reach zero, so a state loaded with N lasts exactly N cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            state_code <= S_IDLE;
            unlock     <= 1'b0;
            alarm      <= 1'b0;
            tries_left <= TRIES_MAX;
            timer      <= '0;
            pwd_we     <= 1'b0;
            pwd_wdata  <= 4'd0;
        end else begin
            pwd_we <= pwd_load;
            if (pwd_load) begin
                pwd_wdata <= sw;
                timer     <= T_OPEN;
            end else if (admin_clr) begin
                state      <= S_IDLE;
                state_code <= S_IDLE;
                unlock     <= 1'b0;
                alarm      <= 1'b0;
                tries_left <= TRIES_MAX;
                timer      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (enter_trig) begin
                            state      <= S_CHECK;
                            state_code <= S_CHECK;
                            timer      <= T_CMP;
                        end
                    end
                    S_CHECK: begin
                        if (timer > T_ONE) begin
                            timer <= timer - T_ONE;
                        end else if (com_result) begin
                            state      <= S_OPEN;
                            state_code <= S_OPEN;
                            unlock     <= 1'b1;
                            tries_left <= TRIES_MAX;
                            timer      <= T_OPEN;
                        end else if (tries_left <= 2'd1) begin
                            // last attempt used: saturate at 0, only ever seen in LOCKOUT
                            state      <= S_LOCKOUT;
                            state_code <= S_LOCKOUT;
                            alarm      <= 1'b1;
                            tries_left <= 2'd0;
                            timer      <= T_LOCK;
                        end else begin
                            state      <= S_FAIL;
                            state_code <= S_FAIL;
                            tries_left <= tries_left - 2'd1;
                            timer      <= T_FAIL;
                        end
                    end
                    S_OPEN: begin
                        if (!enter_trig && (timer > T_ONE)) begin
                            timer <= timer - T_ONE;
                        end else begin
                            state      <= S_IDLE;
                            state_code <= S_IDLE;
                            unlock     <= 1'b0;
                            timer      <= '0;
                        end
                    end
                    S_FAIL: begin
                        if (timer > T_ONE) begin
                            timer <= timer - T_ONE;
                        end else begin
                            state      <= S_IDLE;
                            state_code <= S_IDLE;
                            timer      <= '0;
                        end
                    end
                    S_LOCKOUT: begin
                        if (timer > T_ONE) begin
                            timer <= timer - T_ONE;
                        end else begin
                            state      <= S_IDLE;
                            state_code <= S_IDLE;
                            alarm      <= 1'b0;
                            tries_left <= TRIES_MAX;
                            timer      <= '0;
                        end
                    end
                    default: begin
                        state      <= S_IDLE;
                        state_code <= S_IDLE;
                        unlock     <= 1'b0;
                        alarm      <= 1'b0;
                        tries_left <= TRIES_MAX;
                        timer      <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// tb_lock_seq_ctrl
//   Directed stimulus for lock_seq_ctrl with short timer parameters. The driver
//   pushes the hand-computed output word expected after each clock edge; a
//   monitor on the falling edge pops and compares it against the DUT outputs.
//   Expected word layout: {state_code, unlock, alarm, tries_left, pwd_we, pwd_wdata}.
module tb_lock_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enter_trig = 1'b0;
    logic       init_trig = 1'b0;
    logic       com_result = 1'b0;
    logic [3:0] sw = 4'h0;
    logic       unlock;
    logic       alarm;
    logic [2:0] state_code;
    logic [1:0] tries_left;
    logic       pwd_we;
    logic [3:0] pwd_wdata;

    lock_seq_ctrl #(
        .CMP_LAT(1), .MAX_TRIES(3), .OPEN_CYCLES(8), .FAIL_CYCLES(4), .LOCK_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .enter_trig(enter_trig), .init_trig(init_trig),
        .com_result(com_result), .sw(sw), .unlock(unlock), .alarm(alarm),
        .state_code(state_code), .tries_left(tries_left), .pwd_we(pwd_we),
        .pwd_wdata(pwd_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned id;
        logic [11:0] v;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned step_id = 0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_wd = 4'h0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [11:0] act;
            e = sb.pop_front();
            act = {state_code, unlock, alarm, tries_left, pwd_we, pwd_wdata};
            n_checks++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL step%0d got code=%0d unl=%b alm=%b tries=%0d we=%b wd=%h, expected code=%0d unl=%b alm=%b tries=%0d we=%b wd=%h",
                         e.id, act[11:9], act[8], act[7], act[6:5], act[4], act[3:0],
                         e.v[11:9], e.v[8], e.v[7], e.v[6:5], e.v[4], e.v[3:0]);
            end
        end
    end

    // Apply inputs for one cycle; code/tr are the outputs expected after the edge.
    task automatic step(input logic en, input logic in, input logic cr,
                        input logic [2:0] code, input logic [1:0] tr);
        exp_t e;
        enter_trig = en;
        init_trig  = in;
        com_result = cr;
        @(posedge clk);
        step_id++;
        e.id = step_id;
        e.v  = {code, (code == 3'd2), (code == 3'd4), tr, exp_we, exp_wd};
        sb.push_back(e);
        #1;
        enter_trig = 1'b0;
        init_trig  = 1'b0;
        com_result = 1'b0;
    endtask

    task automatic run(input int n, input logic en, input logic [2:0] code, input logic [1:0] tr);
        for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, code, tr);
    endtask

    // Wrong entry from IDLE with tr tries left (tr >= 2): FAIL for 4 cycles,
    // enter_trig hammered throughout and ignored.
    task automatic wrong_to_fail(input logic [1:0] tr);
        step(1'b1, 1'b0, 1'b0, 3'd1, tr);
        step(1'b0, 1'b0, 1'b0, 3'd3, tr - 2'd1);
        run(3, 1'b1, 3'd3, tr - 2'd1);
        step(1'b1, 1'b0, 1'b0, 3'd0, tr - 2'd1);
    endtask

    initial begin
        // reset values
        rst = 1'b1;
        run(2, 1'b0, 3'd0, 2'd3);
        rst = 1'b0;
        run(1, 1'b0, 3'd0, 2'd3);

        // correct entry: CHECK 1 cycle, OPEN exactly 8 cycles, then IDLE
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd3);
        step(1'b0, 1'b0, 1'b1, 3'd2, 2'd3);
        run(7, 1'b0, 3'd2, 2'd3);
        run(2, 1'b0, 3'd0, 2'd3);

        // three wrong entries, enter_trig every cycle in FAIL and LOCKOUT
        wrong_to_fail(2'd3);
        wrong_to_fail(2'd2);
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd1);
        step(1'b0, 1'b0, 1'b0, 3'd4, 2'd0);
        run(15, 1'b1, 3'd4, 2'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'd3);
        run(1, 1'b0, 3'd0, 2'd3);

        // manual relock in OPEN cycle 3
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd3);
        step(1'b0, 1'b0, 1'b1, 3'd2, 2'd3);
        run(2, 1'b0, 3'd2, 2'd3);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'd3);
        run(1, 1'b0, 3'd0, 2'd3);

        // init+enter in LOCKOUT cycle 5: IDLE, tries restored, no CHECK
        wrong_to_fail(2'd3);
        wrong_to_fail(2'd2);
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd1);
        step(1'b0, 1'b0, 1'b0, 3'd4, 2'd0);
        run(3, 1'b0, 3'd4, 2'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 2'd3);
        run(2, 1'b0, 3'd0, 2'd3);

        // init in CHECK with a matching compare: compare discarded
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd3);
        step(1'b0, 1'b1, 1'b1, 3'd0, 2'd3);
        run(1, 1'b0, 3'd0, 2'd3);

        // rst in CHECK after one failure: tries back to 3
        wrong_to_fail(2'd3);
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd2);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1, 3'd0, 2'd3);
        rst = 1'b0;
        run(2, 1'b0, 3'd0, 2'd3);

        // init in OPEN with sw = A
        sw = 4'hA;
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd3);
        step(1'b0, 1'b0, 1'b1, 3'd2, 2'd3);
        run(1, 1'b0, 3'd2, 2'd3);
`ifdef LOCK_SEQ_PWD_CHANGE_EN
        exp_we = 1'b1;
        exp_wd = 4'hA;
        step(1'b0, 1'b1, 1'b0, 3'd2, 2'd3);
        exp_we = 1'b0;
        run(7, 1'b0, 3'd2, 2'd3);
        run(2, 1'b0, 3'd0, 2'd3);
`else
        step(1'b0, 1'b1, 1'b0, 3'd0, 2'd3);
        run(3, 1'b0, 3'd0, 2'd3);
`endif

        // drain the scoreboard, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
